// File: rtl/evg_heartbeat_gen.sv
// Heartbeat and sequence-start generator for the event generator.
// Measures the revolution-marker period, divides markers into heartbeats and
// heartbeats into sequence starts, and free-runs at the last measured period
// (holdover) when markers stop arriving.
module evg_heartbeat_gen #(
  parameter int unsigned MARKER_PERIOD_WIDTH = 20,
  parameter int unsigned MARKER_TOLERANCE    = 16
) (
  input  logic                           evgTxClk,
  input  logic                           evgTxReset,
  input  logic                           evgEnable,
  input  logic                           evgMarker,
  input  logic [15:0]                    evgHeartbeatInterval,
  input  logic [7:0]                     evgSequenceDivisor,
  output logic                           evgHeartbeatRequest,
  output logic                           evgSequenceStart,
  output logic                           evgMarkerLocked,
  output logic                           evgHoldover,
  output logic [MARKER_PERIOD_WIDTH-1:0] evgMarkerPeriod,
  output logic [15:0]                    evgMissedMarkerCount
);

  localparam int unsigned PW = MARKER_PERIOD_WIDTH;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StAcquire  = 2'd1;
  localparam logic [1:0] StLocked   = 2'd2;
  localparam logic [1:0] StHoldover = 2'd3;

  localparam logic [PW-1:0] SinceMax  = {PW{1'b1}};
  localparam logic [PW-1:0] PeriodOne = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]   Tolerance = (PW+1)'(MARKER_TOLERANCE);

  logic [1:0]    stateQ, stateD;
  logic [PW-1:0] sinceQ, sinceD;
  logic [PW-1:0] periodQ, periodD;
  logic [PW-1:0] holdCntQ, holdCntD;
  logic          acqSeenQ, acqSeenD;
  logic [15:0]   markerCountQ, markerCountD;
  logic [7:0]    hbCountQ, hbCountD;
  logic [15:0]   missedQ, missedD;
  logic          hbPulseQ, hbPulseD;
  logic          seqPulseQ, seqPulseD;

  logic [PW-1:0] sinceInc;
  logic          periodValid;
  logic          timeout;
  logic          tick;
  logic          synthTick;
  logic          hbFire;
  logic          seqFire;

  // Next-state logic: marker tracking FSM, tick generation and tick division.
  always_comb begin
    stateD       = stateQ;
    periodD      = periodQ;
    holdCntD     = holdCntQ;
    acqSeenD     = acqSeenQ;
    markerCountD = markerCountQ;
    hbCountD     = hbCountQ;
    missedD      = missedQ;
    tick         = 1'b0;
    synthTick    = 1'b0;
    hbFire       = 1'b0;
    seqFire      = 1'b0;

    sinceInc    = (sinceQ == SinceMax) ? sinceQ : sinceQ + PeriodOne;
    sinceD      = evgMarker ? '0 : sinceInc;
    // A saturated counter means the gap is too long to be a real period.
    periodValid = (sinceQ != SinceMax);
    timeout     = ({1'b0, sinceQ} == ({1'b0, periodQ} + Tolerance));

    if (!evgEnable || stateQ == StIdle) begin
      stateD       = evgEnable ? StAcquire : StIdle;
      sinceD       = '0;
      periodD      = '0;
      holdCntD     = '0;
      acqSeenD     = 1'b0;
      markerCountD = '0;
      hbCountD     = '0;
    end else begin
      case (stateQ)
        StAcquire: begin
          if (evgMarker) begin
            acqSeenD = 1'b1;
            if (acqSeenQ && periodValid) begin
              periodD = sinceQ + PeriodOne;
              stateD  = StLocked;
            end
          end
        end
        StLocked: begin
          // A real marker always beats a coincident timeout.
          if (evgMarker) begin
            if (periodValid) begin
              tick    = 1'b1;
              periodD = sinceQ + PeriodOne;
            end else begin
              stateD   = StAcquire;
              acqSeenD = 1'b1;
            end
          end else if (timeout) begin
            tick      = 1'b1;
            synthTick = 1'b1;
            holdCntD  = PeriodOne;
            stateD    = StHoldover;
          end
        end
        StHoldover: begin
          // The long gap is not a valid period, so the period is kept.
          if (evgMarker) begin
            tick   = 1'b1;
            stateD = StLocked;
          end else if (holdCntQ >= periodQ) begin
            tick      = 1'b1;
            synthTick = 1'b1;
            holdCntD  = PeriodOne;
          end else begin
            holdCntD = holdCntQ + PeriodOne;
          end
        end
        default: stateD = StIdle;
      endcase
    end

    // >= lets a reduced interval or divisor take effect on the next tick.
    if (tick) begin
      if (evgHeartbeatInterval != 16'd0 &&
          markerCountQ >= evgHeartbeatInterval - 16'd1) begin
        hbFire       = 1'b1;
        markerCountD = '0;
      end else begin
        markerCountD = markerCountQ + 16'd1;
      end
    end

    if (hbFire) begin
      if (evgSequenceDivisor != 8'd0 && hbCountQ >= evgSequenceDivisor - 8'd1) begin
        seqFire  = 1'b1;
        hbCountD = '0;
      end else begin
        hbCountD = hbCountQ + 8'd1;
      end
    end

    if (synthTick && missedQ != 16'hFFFF) begin
      missedD = missedQ + 16'd1;
    end

    hbPulseD  = hbFire;
    seqPulseD = seqFire;
  end

  // State and counter registers with synchronous active-high reset.
  always_ff @(posedge evgTxClk) begin
    if (evgTxReset) begin
      stateQ       <= StIdle;
      sinceQ       <= '0;
      periodQ      <= '0;
      holdCntQ     <= '0;
      acqSeenQ     <= 1'b0;
      markerCountQ <= '0;
      hbCountQ     <= '0;
      missedQ      <= '0;
      hbPulseQ     <= 1'b0;
      seqPulseQ    <= 1'b0;
    end else begin
      stateQ       <= stateD;
      sinceQ       <= sinceD;
      periodQ      <= periodD;
      holdCntQ     <= holdCntD;
      acqSeenQ     <= acqSeenD;
      markerCountQ <= markerCountD;
      hbCountQ     <= hbCountD;
      missedQ      <= missedD;
      hbPulseQ     <= hbPulseD;
      seqPulseQ    <= seqPulseD;
    end
  end

  assign evgHeartbeatRequest  = hbPulseQ;
  assign evgSequenceStart     = seqPulseQ;
  assign evgMarkerLocked      = (stateQ == StLocked);
  assign evgHoldover          = (stateQ == StHoldover);
  assign evgMarkerPeriod      = periodQ;
  assign evgMissedMarkerCount = missedQ;

endmodule

// File: tb/tb_evg_heartbeat_gen.sv
// Randomized bench for evg_heartbeat_gen against a cycle-stamp reference model.
module tb_evg_heartbeat_gen;

  localparam int PW   = 20;
  localparam int TOL  = 16;
  localparam int SMAX = (1 << PW) - 1;

  localparam int MIdle = 0;
  localparam int MAcq  = 1;
  localparam int MLock = 2;
  localparam int MHold = 3;

  logic          evgTxClk = 1'b0;
  logic          evgTxReset;
  logic          evgEnable;
  logic          evgMarker;
  logic [15:0]   evgHeartbeatInterval;
  logic [7:0]    evgSequenceDivisor;
  logic          evgHeartbeatRequest;
  logic          evgSequenceStart;
  logic          evgMarkerLocked;
  logic          evgHoldover;
  logic [PW-1:0] evgMarkerPeriod;
  logic [15:0]   evgMissedMarkerCount;

  evg_heartbeat_gen #(
    .MARKER_PERIOD_WIDTH(PW),
    .MARKER_TOLERANCE   (TOL)
  ) dut (
    .evgTxClk            (evgTxClk),
    .evgTxReset          (evgTxReset),
    .evgEnable           (evgEnable),
    .evgMarker           (evgMarker),
    .evgHeartbeatInterval(evgHeartbeatInterval),
    .evgSequenceDivisor  (evgSequenceDivisor),
    .evgHeartbeatRequest (evgHeartbeatRequest),
    .evgSequenceStart    (evgSequenceStart),
    .evgMarkerLocked     (evgMarkerLocked),
    .evgHoldover         (evgHoldover),
    .evgMarkerPeriod     (evgMarkerPeriod),
    .evgMissedMarkerCount(evgMissedMarkerCount)
  );

  always #5 evgTxClk = ~evgTxClk;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: the model works with absolute cycle stamps.
  int cyc = 0;
  int lastMk = 0;
  int firstSynth = 0;
  int period = 0;
  int mc = 0;
  int hc = 0;
  int missed = 0;
  int mState = MIdle;
  bit acqSeen = 1'b0;
  bit expHb, expSeq, expLock, expHold;
  int expPeriod, expMissed;

  int curIv = 0;
  int curDv = 0;
  bit curEn = 1'b0;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelStep(input bit rst, input bit en, input bit mk, input int iv, input int dv);
    bit tick  = 1'b0;
    bit synth = 1'b0;
    bit hb    = 1'b0;
    bit sq    = 1'b0;
    int s;
    if (rst) begin
      mState = MIdle; lastMk = cyc; acqSeen = 0; period = 0;
      mc = 0; hc = 0; missed = 0; firstSynth = 0;
    end else begin
      // Cycles since the last real marker, saturating.
      s = cyc - lastMk - 1;
      if (s > SMAX) s = SMAX;
      if (!en || mState == MIdle) begin
        mState = en ? MAcq : MIdle;
        lastMk = cyc; acqSeen = 0; period = 0; mc = 0; hc = 0;
      end else if (mState == MAcq) begin
        if (mk) begin
          if (acqSeen && s < SMAX) begin
            period = s + 1;
            mState = MLock;
          end
          acqSeen = 1;
          lastMk  = cyc;
        end
      end else if (mState == MLock) begin
        if (mk) begin
          if (s == SMAX) begin
            mState = MAcq; acqSeen = 1;
          end else begin
            tick = 1; period = s + 1;
          end
          lastMk = cyc;
        end else if (s == period + TOL) begin
          tick = 1; synth = 1; mState = MHold; firstSynth = cyc;
        end
      end else begin
        if (mk) begin
          tick = 1; mState = MLock; lastMk = cyc;
        end else if ((cyc - firstSynth) % period == 0) begin
          tick = 1; synth = 1;
        end
      end
      if (synth && missed < 65535) missed++;
      if (tick) begin
        if (iv != 0 && mc >= iv - 1) begin hb = 1; mc = 0; end
        else mc = (mc + 1) % 65536;
      end
      if (hb) begin
        if (dv != 0 && hc >= dv - 1) begin sq = 1; hc = 0; end
        else hc = (hc + 1) % 256;
      end
    end
    expHb     = hb;
    expSeq    = sq;
    expLock   = (mState == MLock);
    expHold   = (mState == MHold);
    expPeriod = period;
    expMissed = missed;
    cyc++;
  endtask

  // Check the outputs of the previous edge, then drive this cycle's inputs.
  task automatic cycleOnce(input bit rst, input bit en, input bit mk);
    @(negedge evgTxClk);
    checkValue("heartbeat", 32'(evgHeartbeatRequest), 32'(expHb));
    checkValue("seqStart",  32'(evgSequenceStart),    32'(expSeq));
    checkValue("locked",    32'(evgMarkerLocked),     32'(expLock));
    checkValue("holdover",  32'(evgHoldover),         32'(expHold));
    checkValue("period",    32'(evgMarkerPeriod),     expPeriod);
    checkValue("missed",    32'(evgMissedMarkerCount), expMissed);
    evgTxReset           = rst;
    evgEnable            = en;
    evgMarker            = mk;
    evgHeartbeatInterval = 16'(curIv);
    evgSequenceDivisor   = 8'(curDv);
    modelStep(rst, en, mk, curIv, curDv);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycleOnce(1'b0, curEn, 1'b0);
  endtask

  task automatic markers(input int n, input int per, input int jit);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = per - 1 + int'($urandom_range(0, 2 * jit)) - jit;
      if (gap < 0) gap = 0;
      quiet(gap);
      cycleOnce(1'b0, curEn, 1'b1);
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) cycleOnce(1'b1, curEn, 1'b0);
  endtask

  initial begin
    int per;
    evgTxReset = 1'b1; evgEnable = 1'b0; evgMarker = 1'b0;
    evgHeartbeatInterval = 16'd0; evgSequenceDivisor = 8'd0;
    modelStep(1'b1, 1'b0, 1'b0, 0, 0);
    doReset(3);

    // Lock, heartbeat every 4 markers, sequence start every 3 heartbeats.
    curEn = 1'b1; curIv = 4; curDv = 3;
    markers(20, 100, 0);
    // Holdover, then recovery at an arbitrary phase.
    quiet(650);
    quiet(37);
    markers(8, 100, 0);

    // Disable codes.
    curIv = 0;
    markers(10, 100, 0);
    curIv = 1; curDv = 0;
    markers(10, 100, 0);

    // Marker exactly on the timeout cycle.
    curIv = 4; curDv = 3;
    markers(2, 100, 0);
    quiet(116);
    cycleOnce(1'b0, 1'b1, 1'b1);
    markers(3, 100, 0);

    // Reset during holdover, then reacquire.
    quiet(400);
    doReset(2);
    markers(5, 100, 0);

    // Interval lowered from 8 to 2 with five ticks already counted.
    doReset(2);
    curIv = 8; curDv = 2;
    markers(7, 50, 0);
    curIv = 2;
    markers(3, 50, 0);

    // Enable dropping on a tick cycle.
    markers(3, 50, 0);
    quiet(49);
    curEn = 1'b0;
    cycleOnce(1'b0, 1'b0, 1'b1);
    quiet(5);
    curEn = 1'b1;
    markers(5, 50, 0);

    // Randomized segments.
    for (int seg = 0; seg < 25; seg++) begin
      curIv = int'($urandom_range(0, 5));
      curDv = int'($urandom_range(0, 4));
      per   = int'($urandom_range(20, 120));
      markers(int'($urandom_range(3, 8)), per, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) quiet(2 * per + int'($urandom_range(0, 300)));
      if ($urandom_range(0, 5) == 0) begin
        curEn = 1'b0;
        markers(int'($urandom_range(1, 3)), int'($urandom_range(1, 5)), 0);
        curEn = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) doReset(1);
    end
    quiet(5);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
